// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//
// Shared constants for the register-hazard scoreboard and its users (decode,
// pipeline control). Holds the architectural register-file geometry, the
// writeback latency range, the zero-register constant and a small helper that
// normalises an instruction's requested writeback latency.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  // Architectural register file: 32 registers addressed by 5 bits.
  localparam int SB_NUM_REGS = 32;
  localparam int SB_ADDR_W   = 5;

  // Longest writeback latency any functional unit reports, and the largest
  // remaining latency whose result the bypass network can still deliver.
  localparam int SB_MAX_LAT  = 4;
  localparam int SB_FWD_LAT  = 1;

  // Width of one pending counter (must hold 0..SB_MAX_LAT).
  localparam int SB_CNT_W    = $clog2(SB_MAX_LAT + 1);

  // Hard-wired zero register: writes to it are discarded, reads never stall.
  localparam int ZERO_REG    = 0;

  // Width of the stall-cycle performance counter.
  localparam int STALL_W     = 16;

  // Latencies beyond the deepest pipeline are treated as the deepest pipeline.
  // A latency of 0 passes through unchanged and is interpreted as "no write".
  function automatic int clamp_lat(input int lat, input int max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//
// Issue-side handshake between decode and the hazard scoreboard.
//
//   issue_valid      decode presents an instruction this cycle
//   issue_rs_addr    first source register
//   issue_rt_addr    second source register
//   issue_uses_rs    first source is actually read
//   issue_uses_rt    second source is actually read
//   issue_we         instruction writes a destination register
//   issue_wr_addr    destination register
//   issue_lat        cycles until the result reaches writeback (1..MAX_LAT)
//   kill_prev        squash the write accepted in the previous cycle
//   issue_ready      instruction is accepted this cycle (combinational)
//   fwd_rs / fwd_rt  pending count of each source: 0 = register file,
//                    k = bypass from the stage k cycles before writeback
//
// master: decode side.  slave: scoreboard side.
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int CNT_W  = SB_CNT_W
) ();

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs_addr;
  logic [ADDR_W-1:0] issue_rt_addr;
  logic              issue_uses_rs;
  logic              issue_uses_rt;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_wr_addr;
  logic [CNT_W-1:0]  issue_lat;
  logic              kill_prev;
  logic              issue_ready;
  logic [CNT_W-1:0]  fwd_rs;
  logic [CNT_W-1:0]  fwd_rt;

  modport master (
    output issue_valid, issue_rs_addr, issue_rt_addr,
    output issue_uses_rs, issue_uses_rt,
    output issue_we, issue_wr_addr, issue_lat, kill_prev,
    input  issue_ready, fwd_rs, fwd_rt
  );

  modport slave (
    input  issue_valid, issue_rs_addr, issue_rt_addr,
    input  issue_uses_rs, issue_uses_rt,
    input  issue_we, issue_wr_addr, issue_lat, kill_prev,
    output issue_ready, fwd_rs, fwd_rt
  );

endinterface

// File: rtl/sb_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
//
// Pending-writeback counter for one architectural register. The count is the
// number of cycles until the outstanding write to this register reaches
// writeback; 0 means the register file holds the current value.
//
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset, clears the count
//   load      a new write to this register was accepted this cycle
//   load_val  writeback latency of that write (nonzero)
//   clear     the previously accepted write to this register was squashed
//   count     current pending count
//
// Priority at the edge: load > clear > decrement. A fresh write therefore
// survives a same-cycle squash of the older write to the same register.
// -----------------------------------------------------------------------------
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments, and every counter is
  // reset explicitly: a stale nonzero count after reset would stall decode on a
  // write that no longer exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register-hazard scoreboard for an in-order issue stage. Tracks, per
// architectural register, how many cycles remain until its outstanding write
// reaches writeback, and decides each cycle whether the instruction presented
// by decode may issue.
//
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   sb_if         issue handshake (slave side), see hazard_scoreboard_if
//   busy          some register still has a write in flight
//   stall_cycles  saturating count of cycles decode was held off
//
// An instruction is held off when
//   RAW: a used source is still further from writeback than the bypass
//        network can reach (count > FWD_LAT), or
//   WAW: its own write would retire before an older write to the same
//        destination (older count > new latency).
// Register 0 never becomes pending, so it never causes either hazard.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  NUM_REGS = SB_NUM_REGS,
  parameter int  ADDR_W   = SB_ADDR_W,
  parameter int  MAX_LAT  = SB_MAX_LAT,
  parameter int  FWD_LAT  = SB_FWD_LAT,
  localparam int CNT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave sb_if,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cycles
);

  // Last accepted destination, kept for exactly one cycle so a squash of the
  // delay/branch slot can retract it.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } kill_rec_t;

  localparam logic [CNT_W-1:0]   FWD_LIM   = CNT_W'(FWD_LAT);
  localparam logic [ADDR_W-1:0]  ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [STALL_W-1:0] STALL_SAT = '1;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    rs_cnt;
  logic [CNT_W-1:0]    rt_cnt;
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    lat_eff;
  logic                wr_req;
  logic                raw_rs;
  logic                raw_rt;
  logic                waw;
  logic                ready;
  logic                wr_en;
  logic                kill_en;
  logic [NUM_REGS-1:1] load_vec;
  logic [NUM_REGS-1:1] clear_vec;
  kill_rec_t           kill_rec;

  // ---------------------------------------------------------------------------
  // Per-register pending counters. Register 0 has no storage and reads 0.
  // ---------------------------------------------------------------------------
  assign cnt[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_vec[i]),
      .load_val (lat_eff),
      .clear    (clear_vec[i]),
      .count    (cnt[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and accept decision
  // ---------------------------------------------------------------------------
  always_comb begin
    lat_eff = CNT_W'(clamp_lat(int'(sb_if.issue_lat), MAX_LAT));
    rs_cnt  = cnt[sb_if.issue_rs_addr];
    rt_cnt  = cnt[sb_if.issue_rt_addr];
    wr_cnt  = cnt[sb_if.issue_wr_addr];

    // A zero latency or a zero destination produces no tracked write.
    wr_req  = sb_if.issue_we && (sb_if.issue_wr_addr != ZERO_ADDR) &&
              (lat_eff != '0);

    raw_rs  = sb_if.issue_uses_rs && (rs_cnt != '0) && (rs_cnt > FWD_LIM);
    raw_rt  = sb_if.issue_uses_rt && (rt_cnt != '0) && (rt_cnt > FWD_LIM);
    waw     = wr_req && (wr_cnt > lat_eff);

    // Gated by rst_n so nothing issues while the scoreboard is being cleared.
    ready   = rst_n && sb_if.issue_valid && !raw_rs && !raw_rt && !waw;
    wr_en   = ready && wr_req;
    kill_en = sb_if.kill_prev && kill_rec.valid;
  end

  assign sb_if.issue_ready = ready;
  assign sb_if.fwd_rs      = rs_cnt;
  assign sb_if.fwd_rt      = rt_cnt;

  // ---------------------------------------------------------------------------
  // Address decode of the load and squash requests onto the entries.
  // ---------------------------------------------------------------------------
  // NOTE: combinational outputs get a default before any conditional or loop
  // assignment, so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    load_vec  = '0;
    clear_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      load_vec[i]  = wr_en   && (sb_if.issue_wr_addr == ADDR_W'(i));
      clear_vec[i] = kill_en && (kill_rec.addr       == ADDR_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // One-cycle record of the last accepted write, for kill_prev.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_rec <= '0;
    end else begin
      kill_rec.valid <= wr_en;
      kill_rec.addr  <= sb_if.issue_wr_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Status: any write in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy = busy || (cnt[i] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stall performance counter, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (sb_if.issue_valid && !ready && (stall_cycles != STALL_SAT)) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard. The reference model stores, per
// register, the absolute cycle at which its outstanding write reaches
// writeback; the pending count at any cycle is that time minus the current
// cycle (floored at 0). Every cycle the DUT outputs are compared with the model
// on the falling clock edge; directed scenarios add explicit expectations.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int MAXL  = 4;
  localparam int FWD   = 1;
  localparam int CW    = $clog2(MAXL + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(AW), .CNT_W(CW)) sb_if ();

  hazard_scoreboard #(
    .NUM_REGS (NREGS),
    .ADDR_W   (AW),
    .MAX_LAT  (MAXL),
    .FWD_LAT  (FWD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sb_if        (sb_if),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  // Stimulus currently applied
  logic s_valid, s_urs, s_urt, s_we, s_kill;
  int   s_rs, s_rt, s_wr, s_lat;

  // Reference model
  int wb_time [NREGS];
  int cyc;
  int last_wr_cyc;
  int last_wr_addr;
  int stalls;

  // Observations of the most recent cycle
  logic obs_ready, obs_busy;
  int   obs_fwd_rs, obs_stall;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mcnt(input int r);
    if (r == 0) return 0;
    return (wb_time[r] > cyc) ? wb_time[r] - cyc : 0;
  endfunction

  task automatic mclear();
    for (int r = 0; r < NREGS; r++) wb_time[r] = 0;
    last_wr_cyc = -10;
    last_wr_addr = 0;
    stalls = 0;
  endtask

  task automatic apply(input logic v, input int rs, input logic urs, input int rt,
                       input logic urt, input logic we, input int wr, input int lat,
                       input logic kill);
    s_valid = v;  s_rs = rs;  s_urs = urs;  s_rt = rt;  s_urt = urt;
    s_we = we;    s_wr = wr;  s_lat = lat;  s_kill = kill;
    sb_if.issue_valid   = v;
    sb_if.issue_rs_addr = AW'(rs);
    sb_if.issue_uses_rs = urs;
    sb_if.issue_rt_addr = AW'(rt);
    sb_if.issue_uses_rt = urt;
    sb_if.issue_we      = we;
    sb_if.issue_wr_addr = AW'(wr);
    sb_if.issue_lat     = CW'(lat);
    sb_if.kill_prev     = kill;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then move
  // to just after the next rising edge.
  task automatic tick();
    int   c_rs, c_rt, c_wr, le;
    logic wr_req, exp_ready, exp_busy, kill_ok;
    @(negedge clk);
    c_rs = mcnt(s_rs);
    c_rt = mcnt(s_rt);
    c_wr = mcnt(s_wr);
    le   = (s_lat > MAXL) ? MAXL : s_lat;
    wr_req    = s_we && (s_wr != 0) && (le != 0);
    exp_ready = rst_n && s_valid && !(s_urs && c_rs > FWD) && !(s_urt && c_rt > FWD) &&
                !(wr_req && c_wr > le);
    exp_busy = 1'b0;
    for (int r = 1; r < NREGS; r++) if (mcnt(r) != 0) exp_busy = 1'b1;

    check("issue_ready", 32'(sb_if.issue_ready), 32'(exp_ready));
    check("fwd_rs", 32'(sb_if.fwd_rs), c_rs);
    check("fwd_rt", 32'(sb_if.fwd_rt), c_rt);
    check("busy", 32'(busy), 32'(exp_busy));
    check("stall_cycles", 32'(stall_cycles), stalls);

    obs_ready  = sb_if.issue_ready;
    obs_busy   = busy;
    obs_fwd_rs = int'(sb_if.fwd_rs);
    obs_stall  = int'(stall_cycles);

    if (rst_n) begin
      kill_ok = s_kill && (last_wr_cyc == cyc - 1);
      if (kill_ok) wb_time[last_wr_addr] = cyc + 1;
      last_wr_cyc = -10;
      if (exp_ready && wr_req) begin
        wb_time[s_wr] = cyc + 1 + le;
        last_wr_cyc   = cyc;
        last_wr_addr  = s_wr;
      end
      if (s_valid && !exp_ready && stalls < 65535) stalls++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input logic v, input int rs, input logic urs, input int rt,
                       input logic urt, input logic we, input int wr, input int lat,
                       input logic kill);
    apply(v, rs, urs, rt, urt, we, wr, lat, kill);
    tick();
  endtask

  task automatic wr(input int r, input int lat);
    issue(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, r, lat, 1'b0);
  endtask

  task automatic rd(input int r);
    issue(1'b1, r, 1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_waw;
    logic got;

    cyc = 0;
    mclear();
    apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset state: nothing pending, a presented instruction is held off.
    rd(3);
    check("rst_ready_low", 32'(obs_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stall_cnt", 32'(stall_cycles), 0);
    rst_n = 1'b1;

    // Load-use: lat=2 write to $t0, then read $t0.
    wr(8, 2);
    rd(8);
    check("lu_stall", 32'(obs_ready), 0);
    rd(8);
    check("lu_accept", 32'(obs_ready), 1);
    check("lu_fwd", obs_fwd_rs, 1);
    check("lu_stall_cnt", obs_stall, 1);

    // ALU forwarding: lat=1 write to $t1, then read $t1.
    wr(9, 1);
    rd(9);
    check("alu_accept", 32'(obs_ready), 1);
    check("alu_fwd", obs_fwd_rs, 1);

    // WAW: lat=4 write to $t2, then lat=1 write to $t2 re-presented until taken.
    wr(10, 4);
    n_waw = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      wr(10, 1);
      if (obs_ready) got = 1'b1;
      else n_waw++;
    end
    check("waw_stalls", n_waw, 3);
    check("waw_accept", 32'(got), 1);

    // Kill: lat=3 write to $t3, squashed the next cycle.
    idle(4);
    wr(11, 3);
    issue(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    rd(11);
    check("kill_ready", 32'(obs_ready), 1);
    check("kill_busy", 32'(obs_busy), 0);

    // Zero register: write to $0 never becomes pending.
    wr(0, 4);
    rd(0);
    check("zero_ready", 32'(obs_ready), 1);
    check("zero_busy", 32'(obs_busy), 0);

    // Kill with no valid record is ignored.
    wr(12, 4);
    idle(1);
    issue(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    rd(12);
    check("kill_ignored_fwd", obs_fwd_rs, 2);

    // A same-cycle accepted write to the killed register wins.
    idle(3);
    wr(13, 2);
    issue(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 13, 4, 1'b1);
    rd(13);
    check("kill_vs_issue_fwd", obs_fwd_rs, 4);

    // Clamp: latency 7 is treated as MAX_LAT.
    idle(5);
    wr(5, 7);
    rd(5);
    check("clamp_fwd", obs_fwd_rs, MAXL);

    // Reset mid-operation with a counter at 3.
    idle(5);
    wr(14, 3);
    apply(1'b1, 14, 1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_fwd", 32'(sb_if.fwd_rs), 3);
    rst_n = 1'b0;
    mclear();
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_stall", 32'(stall_cycles), 0);
    check("rst_mid_fwd", 32'(sb_if.fwd_rs), 0);
    check("rst_mid_ready", 32'(sb_if.issue_ready), 0);
    tick();
    tick();
    rst_n = 1'b1;
    rd(14);
    check("post_rst_ready14", 32'(obs_ready), 1);
    check("post_rst_fwd14", obs_fwd_rs, 0);
    rd(12);
    check("post_rst_ready12", 32'(obs_ready), 1);

    // Randomised traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply(1'b1, 1, 1'b1, 2, 1'b1, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        mclear();
        tick();
        tick();
        rst_n = 1'b1;
      end
      issue(($urandom_range(0, 9) < 8),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers tracked.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (log2 NUM_REGS).
REQ-003 SHALL have parameter MAX_LAT, default 4, largest writeback latency in cycles; CNT_W = clog2(MAX_LAT+1).
REQ-004 SHALL have parameter FWD_LAT, default 1, the largest remaining latency at which a result is still forwardable without a stall.
REQ-005 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port issue_valid, input, 1, decode presents an instruction.
REQ-008 SHALL have ports issue_rs_addr and issue_rt_addr, input, ADDR_W each, source registers.
REQ-009 SHALL have ports issue_uses_rs and issue_uses_rt, input, 1 each, qualifying the sources.
REQ-010 SHALL have ports issue_we (input, 1), issue_wr_addr (input, ADDR_W) and issue_lat (input, CNT_W, value 1..MAX_LAT), the destination write.
REQ-011 SHALL have port kill_prev, input, 1, cancelling the write accepted in the previous cycle (squashed delay/branch slot).
REQ-012 SHALL have port issue_ready, output, 1, high when the presented instruction is accepted this cycle.
REQ-013 SHALL have ports fwd_rs and fwd_rt, output, CNT_W each, the current pending count of each source (0 = read the register file; k = forward from the stage k cycles from writeback).
REQ-014 SHALL have port busy, output, 1, high when any pending count is nonzero.
REQ-015 SHALL have port stall_cycles, output, 16, a saturating count of cycles with issue_valid high and issue_ready low.

Function
REQ-016 SHALL hold one pending counter per register; register 0 SHALL never become pending.
REQ-017 SHALL decrement every nonzero counter by 1 each cycle.
REQ-018 SHALL flag a RAW hazard when a used source is nonzero and its count exceeds FWD_LAT.
REQ-019 SHALL flag a WAW hazard when issue_we is high, the destination is nonzero, and its count exceeds issue_lat.
REQ-020 SHALL drive issue_ready = issue_valid AND no RAW hazard AND no WAW hazard, combinationally, in the same cycle.
REQ-021 SHALL, on accept with issue_we high and a nonzero destination, load the destination counter with issue_lat at the next edge. The load SHALL take precedence over the decrement of that counter.
REQ-022 SHALL record the last accepted destination (address plus a valid flag) for one cycle, to serve kill_prev.
REQ-023 SHALL, on kill_prev with a valid record, clear that register's counter. A same-cycle accepted issue to the same register SHALL win over the kill.
REQ-024 SHALL ignore kill_prev when the record is not valid.
REQ-025 SHALL saturate stall_cycles at 16'hFFFF, with no wrap.
REQ-026 SHALL treat issue_lat = 0 as "no write" and issue_lat > MAX_LAT as clamped to MAX_LAT.

Reset
REQ-027 SHALL, on rst_n low, immediately clear all counters, the kill record and stall_cycles, and drive busy and fwd_rs/fwd_rt to 0.
REQ-028 SHALL keep issue_ready low while rst_n is low.
REQ-029 SHALL discard any write in flight when reset is asserted mid-operation; after release, all registers read as not pending.

Structure
REQ-030 SHALL take ADDR_W, MAX_LAT and the ZERO register constant from the shared mips_defines/hazard package.
REQ-031 SHALL implement one per-register counter as sub-module sb_entry (load, decrement, clear), instantiated NUM_REGS-1 times.

Verification
REQ-032 SHALL verify load-use stall: lat=2 write to $t0, next cycle read of $t0 -> issue_ready=0 for 1 cycle, then 1 with fwd_rs=1; stall_cycles=1.
REQ-033 SHALL verify ALU forwarding: lat=1 write to $t1, next-cycle read -> issue_ready=1, fwd_rs=1.
REQ-034 SHALL verify WAW: lat=4 write to $t2, then lat=1 write to $t2 -> stall 3 cycles, then accept.
REQ-035 SHALL verify kill: lat=3 write to $t3 accepted, kill_prev next cycle -> busy=0, and a read of $t3 is ready immediately.
REQ-036 SHALL verify the zero register: lat=4 write to $0 followed by a read of $0 -> no stall, busy=0.
REQ-037 SHALL verify reset: rst_n low while counters are at 3 -> busy=0 and stall_cycles=0 immediately; after release, reads of any register are ready.
